// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB
// for the shared datapath and counts retired instructions.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   opcode, func        IR[31:26], IR[5:0]
//   zero, mem_ready     ALU zero flag, memory handshake
//   pc_write..alu_op    datapath control strobes and selects
//   instr_type          registered decode of the current instruction
//   state               FSM state (FETCH 0 .. WB 4)
//   illegal             pulse in DECODE for unsupported codes
//   retired             retired-instruction counter
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  func,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        ir_write,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_op,
  output logic [4:0]  instr_type,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [4:0] T_NONE = 5'd0;
  localparam logic [4:0] T_ADD  = 5'd1;
  localparam logic [4:0] T_SUB  = 5'd2;
  localparam logic [4:0] T_OR   = 5'd3;
  localparam logic [4:0] T_AND  = 5'd4;
  localparam logic [4:0] T_SLT  = 5'd5;
  localparam logic [4:0] T_SW   = 5'd6;
  localparam logic [4:0] T_LW   = 5'd7;
  localparam logic [4:0] T_ADDI = 5'd8;
  localparam logic [4:0] T_ANDI = 5'd9;
  localparam logic [4:0] T_ORI  = 5'd10;
  localparam logic [4:0] T_BEQ  = 5'd11;
  localparam logic [4:0] T_BNE  = 5'd12;
  localparam logic [4:0] T_SLTI = 5'd13;
  localparam logic [4:0] T_J    = 5'd14;

  state_t      cur_state;
  state_t      nxt_state;
  logic [4:0]  dec_type;
  logic        retire;
  logic        is_rtype;
  logic        is_imm;
  logic        is_ldst;
  logic        is_br;

  assign state = cur_state;

  always_comb begin
    dec_type = T_NONE;
    case (opcode)
      6'h00: begin
        case (func)
          6'h20:   dec_type = T_ADD;
          6'h22:   dec_type = T_SUB;
          6'h24:   dec_type = T_AND;
          6'h25:   dec_type = T_OR;
          6'h2A:   dec_type = T_SLT;
          default: dec_type = T_NONE;
        endcase
      end
      6'h23:   dec_type = T_LW;
      6'h2B:   dec_type = T_SW;
      6'h08:   dec_type = T_ADDI;
      6'h0C:   dec_type = T_ANDI;
      6'h0D:   dec_type = T_ORI;
      6'h0A:   dec_type = T_SLTI;
      6'h04:   dec_type = T_BEQ;
      6'h05:   dec_type = T_BNE;
      6'h02:   dec_type = T_J;
      default: dec_type = T_NONE;
    endcase
  end

  assign is_rtype = (instr_type >= T_ADD) && (instr_type <= T_SLT);
  assign is_imm   = (instr_type == T_ADDI) || (instr_type == T_ANDI) ||
                    (instr_type == T_ORI)  || (instr_type == T_SLTI);
  assign is_ldst  = (instr_type == T_LW) || (instr_type == T_SW);
  assign is_br    = (instr_type == T_BEQ) || (instr_type == T_BNE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_state  <= S_FETCH;
      instr_type <= T_NONE;
      retired    <= 32'd0;
    end else begin
      cur_state <= nxt_state;
      if (cur_state == S_DECODE)
        instr_type <= dec_type;
      if (retire)
        retired <= retired + 32'd1;
    end
  end

  always_comb begin
    nxt_state  = cur_state;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 4'b0000;
    illegal    = 1'b0;
    retire     = 1'b0;

    case (cur_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          nxt_state = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        if (dec_type == T_NONE) begin
          illegal   = 1'b1;
          nxt_state = S_FETCH;
        end else begin
          nxt_state = S_EXEC;
        end
      end
      S_EXEC: begin
        unique case (1'b1)
          is_rtype: begin
            alu_src_a = 1'b1;
            nxt_state = S_WB;
            case (instr_type)
              T_SUB:   alu_op = 4'b0001;
              T_AND:   alu_op = 4'b0010;
              T_OR:    alu_op = 4'b0011;
              T_SLT:   alu_op = 4'b0111;
              default: alu_op = 4'b0000;
            endcase
          end
          is_imm: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            nxt_state = S_WB;
            case (instr_type)
              T_ANDI:  alu_op = 4'b0010;
              T_ORI:   alu_op = 4'b0011;
              T_SLTI:  alu_op = 4'b0111;
              default: alu_op = 4'b0000;
            endcase
          end
          is_ldst: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            nxt_state = S_MEM;
          end
          is_br: begin
            alu_src_a = 1'b1;
            pc_src    = 2'b01;
            nxt_state = S_FETCH;
            if (instr_type == T_BEQ) begin
              alu_op   = 4'b0101;
              pc_write = zero;
            end else begin
              alu_op   = 4'b0110;
              pc_write = ~zero;
            end
          end
          (instr_type == T_J): begin
            pc_src    = 2'b10;
            pc_write  = 1'b1;
            nxt_state = S_FETCH;
          end
          default: nxt_state = S_FETCH;
        endcase
      end
      S_MEM: begin
        i_or_d = 1'b1;
        if (instr_type == T_LW)
          mem_read = 1'b1;
        else
          mem_write = 1'b1;
        if (mem_ready)
          nxt_state = (instr_type == T_LW) ? S_WB : S_FETCH;
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = is_rtype;
        mem_to_reg = (instr_type == T_LW);
        nxt_state  = S_FETCH;
      end
      default: nxt_state = S_FETCH;
    endcase

    // Only EXEC/MEM/WB can finish a legal instruction; DECODE->FETCH is illegal.
    retire = (cur_state != S_FETCH) && (cur_state != S_DECODE) &&
             (nxt_state == S_FETCH);

    // Reset is synchronous, so the old state is still visible this cycle;
    // keep it from writing anything.
    if (!rst_n) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
      retire    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl.
// Walks each instruction class through the FSM and checks controls.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = 6'h00;
  logic [5:0]  func = 6'h00;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        ir_write;
  logic        i_or_d;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [3:0]  alu_op;
  logic [4:0]  instr_type;
  logic [2:0]  state;
  logic        illegal;
  logic [31:0] retired;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_ret = 32'd0;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write),
    .pc_src(pc_src), .ir_write(ir_write), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op),
    .instr_type(instr_type), .state(state), .illegal(illegal),
    .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    tick();
    #1;
    n_checks++;
    if ({state, instr_type, illegal, retired} !== {3'd0, 5'd0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_state got=%0d/%0d/%0d/%0d exp=0/0/0/0", state, instr_type, illegal, retired);
    end
    n_checks++;
    if ({pc_write, ir_write, mem_read, mem_write, reg_write} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_strobes got=%b exp=00000", {pc_write, ir_write, mem_read, mem_write, reg_write});
    end
    rst_n = 1'b1;
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if ({state, mem_read, ir_write} !== {3'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_release got=%b exp=%b", {state, mem_read, ir_write}, {3'd0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_add();
    opcode = 6'h00;
    func = 6'h20;
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if ({state, mem_read, i_or_d, ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_op}
        !== {3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b01, 4'b0000}) begin
      n_fail++;
      $display("FAIL add_fetch got=%b", {state, mem_read, i_or_d, ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_op});
    end
    tick();
    n_checks++;
    if ({state, alu_src_a, alu_src_b, alu_op, illegal, mem_read, pc_write}
        !== {3'd1, 1'b0, 2'b11, 4'b0000, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL add_decode got=%b", {state, alu_src_a, alu_src_b, alu_op, illegal, mem_read, pc_write});
    end
    tick();
    n_checks++;
    if ({state, instr_type, alu_src_a, alu_src_b, alu_op, reg_write}
        !== {3'd2, 5'd1, 1'b1, 2'b00, 4'b0000, 1'b0}) begin
      n_fail++;
      $display("FAIL add_exec got=%b", {state, instr_type, alu_src_a, alu_src_b, alu_op, reg_write});
    end
    tick();
    n_checks++;
    if ({state, reg_write, reg_dst, mem_to_reg, retired}
        !== {3'd4, 1'b1, 1'b1, 1'b0, exp_ret}) begin
      n_fail++;
      $display("FAIL add_wb got=%0d/%b%b%b ret=%0d exp=4/110 ret=%0d", state, reg_write, reg_dst, mem_to_reg, retired, exp_ret);
    end
    tick();
    exp_ret++;
    n_checks++;
    if ({state, retired} !== {3'd0, exp_ret}) begin
      n_fail++;
      $display("FAIL add_retire got=%0d/%0d exp=0/%0d", state, retired, exp_ret);
    end
  endtask

  task automatic test_rtype(input logic [5:0] f, input logic [4:0] et,
                            input logic [3:0] eop);
    opcode = 6'h00;
    func = f;
    mem_ready = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({state, instr_type, alu_src_a, alu_src_b, alu_op}
        !== {3'd2, et, 1'b1, 2'b00, eop}) begin
      n_fail++;
      $display("FAIL rtype_exec func=%h got=%b exp=%b", f, {state, instr_type, alu_src_a, alu_src_b, alu_op}, {3'd2, et, 1'b1, 2'b00, eop});
    end
    tick();
    n_checks++;
    if ({state, reg_write, reg_dst, mem_to_reg} !== {3'd4, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL rtype_wb func=%h got=%b exp=100110", f, {state, reg_write, reg_dst, mem_to_reg});
    end
    tick();
    exp_ret++;
    n_checks++;
    if ({state, retired} !== {3'd0, exp_ret}) begin
      n_fail++;
      $display("FAIL rtype_retire got=%0d/%0d exp=0/%0d", state, retired, exp_ret);
    end
  endtask

  task automatic test_imm(input logic [5:0] op, input logic [4:0] et,
                          input logic [3:0] eop);
    opcode = op;
    func = 6'h3F;
    mem_ready = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({state, instr_type, alu_src_a, alu_src_b, alu_op}
        !== {3'd2, et, 1'b1, 2'b10, eop}) begin
      n_fail++;
      $display("FAIL imm_exec op=%h got=%b exp=%b", op, {state, instr_type, alu_src_a, alu_src_b, alu_op}, {3'd2, et, 1'b1, 2'b10, eop});
    end
    tick();
    n_checks++;
    if ({state, reg_write, reg_dst, mem_to_reg} !== {3'd4, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL imm_wb op=%h got=%b exp=100100", op, {state, reg_write, reg_dst, mem_to_reg});
    end
    tick();
    exp_ret++;
    n_checks++;
    if ({state, retired} !== {3'd0, exp_ret}) begin
      n_fail++;
      $display("FAIL imm_retire got=%0d/%0d exp=0/%0d", state, retired, exp_ret);
    end
  endtask

  task automatic test_lw_stall();
    opcode = 6'h23;
    func = 6'h00;
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if ({state, mem_read, i_or_d, ir_write, pc_write} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL lw_fetch_stall%0d got=%b exp=0001000", i, {state, mem_read, i_or_d, ir_write, pc_write});
      end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if ({state, ir_write, pc_write} !== {3'd0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL lw_fetch_done got=%b exp=00011", {state, ir_write, pc_write});
    end
    tick();
    tick();
    n_checks++;
    if ({state, instr_type, alu_src_a, alu_src_b, alu_op}
        !== {3'd2, 5'd7, 1'b1, 2'b10, 4'b0000}) begin
      n_fail++;
      $display("FAIL lw_exec got=%b", {state, instr_type, alu_src_a, alu_src_b, alu_op});
    end
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({state, mem_read, mem_write, i_or_d} !== {3'd3, 1'b1, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL lw_mem_stall%0d got=%b exp=011101", i, {state, mem_read, mem_write, i_or_d});
      end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if ({state, mem_read, i_or_d} !== {3'd3, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL lw_mem_done got=%b exp=01111", {state, mem_read, i_or_d});
    end
    tick();
    n_checks++;
    if ({state, reg_write, reg_dst, mem_to_reg} !== {3'd4, 1'b1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL lw_wb got=%b exp=100101", {state, reg_write, reg_dst, mem_to_reg});
    end
    tick();
    exp_ret++;
    n_checks++;
    if ({state, retired} !== {3'd0, exp_ret}) begin
      n_fail++;
      $display("FAIL lw_retire got=%0d/%0d exp=0/%0d", state, retired, exp_ret);
    end
  endtask

  task automatic test_branch(input logic [5:0] op, input logic z,
                             input logic epw);
    logic [3:0] eop;
    logic [4:0] et;
    eop = (op == 6'h04) ? 4'b0101 : 4'b0110;
    et = (op == 6'h04) ? 5'd11 : 5'd12;
    opcode = op;
    mem_ready = 1'b1;
    zero = ~z;
    tick();
    tick();
    zero = z;
    #1;
    n_checks++;
    if ({state, instr_type, pc_src, pc_write, alu_src_a, alu_src_b, alu_op}
        !== {3'd2, et, 2'b01, epw, 1'b1, 2'b00, eop}) begin
      n_fail++;
      $display("FAIL branch_exec op=%h z=%b got=%b exp=%b", op, z, {state, instr_type, pc_src, pc_write, alu_src_a, alu_src_b, alu_op}, {3'd2, et, 2'b01, epw, 1'b1, 2'b00, eop});
    end
    tick();
    exp_ret++;
    n_checks++;
    if ({state, retired} !== {3'd0, exp_ret}) begin
      n_fail++;
      $display("FAIL branch_retire got=%0d/%0d exp=0/%0d", state, retired, exp_ret);
    end
  endtask

  task automatic test_jump();
    opcode = 6'h02;
    mem_ready = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({state, instr_type, pc_src, pc_write, reg_write}
        !== {3'd2, 5'd14, 2'b10, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL jump_exec got=%b", {state, instr_type, pc_src, pc_write, reg_write});
    end
    tick();
    exp_ret++;
    n_checks++;
    if ({state, retired} !== {3'd0, exp_ret}) begin
      n_fail++;
      $display("FAIL jump_retire got=%0d/%0d exp=0/%0d", state, retired, exp_ret);
    end
  endtask

  task automatic test_sw();
    logic seen_rw;
    seen_rw = 1'b0;
    opcode = 6'h2B;
    mem_ready = 1'b1;
    tick();
    seen_rw |= reg_write;
    tick();
    seen_rw |= reg_write;
    n_checks++;
    if ({state, instr_type, alu_src_a, alu_src_b, alu_op}
        !== {3'd2, 5'd6, 1'b1, 2'b10, 4'b0000}) begin
      n_fail++;
      $display("FAIL sw_exec got=%b", {state, instr_type, alu_src_a, alu_src_b, alu_op});
    end
    tick();
    mem_ready = 1'b0;
    #1;
    seen_rw |= reg_write;
    n_checks++;
    if ({state, mem_write, mem_read, i_or_d} !== {3'd3, 1'b1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL sw_mem got=%b exp=011101", {state, mem_write, mem_read, i_or_d});
    end
    mem_ready = 1'b1;
    tick();
    exp_ret++;
    n_checks++;
    if ({state, retired, seen_rw} !== {3'd0, exp_ret, 1'b0}) begin
      n_fail++;
      $display("FAIL sw_retire got=%0d/%0d rw=%b exp=0/%0d rw=0", state, retired, seen_rw, exp_ret);
    end
  endtask

  task automatic test_illegal();
    opcode = 6'h3F;
    mem_ready = 1'b1;
    tick();
    n_checks++;
    if ({state, illegal, reg_write, mem_write, mem_read, pc_write, ir_write}
        !== {3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL illegal_decode got=%b exp=001100000", {state, illegal, reg_write, mem_write, mem_read, pc_write, ir_write});
    end
    tick();
    n_checks++;
    if ({state, illegal, instr_type, retired} !== {3'd0, 1'b0, 5'd0, exp_ret}) begin
      n_fail++;
      $display("FAIL illegal_after got=%0d/%b/%0d/%0d exp=0/0/0/%0d", state, illegal, instr_type, retired, exp_ret);
    end
  endtask

  task automatic test_reset_mid_mem();
    opcode = 6'h23;
    mem_ready = 1'b1;
    tick();
    tick();
    tick();
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if ({state, mem_read} !== {3'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL rstmem_pre got=%b exp=0111", {state, mem_read});
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({mem_read, mem_write, reg_write} !== 3'b000) begin
      n_fail++;
      $display("FAIL rstmem_forced got=%b exp=000", {mem_read, mem_write, reg_write});
    end
    tick();
    exp_ret = 32'd0;
    n_checks++;
    if ({state, mem_read, instr_type, retired} !== {3'd0, 1'b0, 5'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL rstmem_after got=%0d/%b/%0d/%0d exp=0/0/0/0", state, mem_read, instr_type, retired);
    end
    rst_n = 1'b1;
    test_rtype(6'h20, 5'd1, 4'b0000);
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_stall();
    test_branch(6'h04, 1'b1, 1'b1);
    test_branch(6'h04, 1'b0, 1'b0);
    test_branch(6'h05, 1'b1, 1'b0);
    test_branch(6'h05, 1'b0, 1'b1);
    test_jump();
    test_sw();
    test_illegal();
    test_rtype(6'h22, 5'd2, 4'b0001);
    test_rtype(6'h24, 5'd4, 4'b0010);
    test_rtype(6'h25, 5'd3, 4'b0011);
    test_rtype(6'h2A, 5'd5, 4'b0111);
    test_imm(6'h08, 5'd8, 4'b0000);
    test_imm(6'h0C, 5'd9, 4'b0010);
    test_imm(6'h0D, 5'd10, 4'b0011);
    test_imm(6'h0A, 5'd13, 4'b0111);
    test_reset_mid_mem();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
